// File: rtl/alu_pkg.sv
// Shared definitions for the ALU-side datapath blocks: FSM encodings and default width.
// Purely declarative; no logic.
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DIV_WIDTH = 8;

endpackage

// File: rtl/bit_subtractor.sv
// One-bit full subtractor (D = A - B - Bin), purely combinational, zero latency.
// No handshake; chained by the caller into a ripple borrow path.
module bit_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  assign D    = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock; done WIDTH cycles after acceptance (1 for /0).
// start is only sampled while not busy; a start during RUN is dropped, never queued.
module seq_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state_q;
  logic [WIDTH-1:0] qr_q, dvs_q;
  logic [WIDTH:0]   pr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, done_q, dbz_q;
  logic [WIDTH-1:0] quot_q, rem_q;

  logic [WIDTH:0]   shift_val, sub_b, diff_val, pr_d;
  logic [WIDTH+1:0] bchain;
  logic [WIDTH-1:0] qr_d;
  logic             borrow_out;
  logic             unused_msb;

  assign shift_val = {pr_q[WIDTH-1:0], qr_q[WIDTH-1]};
  assign sub_b     = {1'b0, dvs_q};
  assign bchain[0] = 1'b0;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_sub
    bit_subtractor u_bit (
      .A   (shift_val[i]),
      .B   (sub_b[i]),
      .Bin (bchain[i]),
      .D   (diff_val[i]),
      .Bout(bchain[i+1])
    );
  end

  assign borrow_out = bchain[WIDTH+1];
  assign pr_d       = borrow_out ? shift_val : diff_val;
  assign qr_d       = {qr_q[WIDTH-2:0], ~borrow_out};
  // Partial remainder never reaches 2**WIDTH, so the top bits carry no information.
  assign unused_msb = ^{pr_q[WIDTH], diff_val[WIDTH]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      qr_q    <= '0;
      pr_q    <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
          if (start) begin
            if (divisor == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              dbz_q   <= 1'b1;
              quot_q  <= '1;
              rem_q   <= dividend;
            end else begin
              qr_q    <= dividend;
              pr_q    <= '0;
              dvs_q   <= divisor;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          pr_q  <= pr_d;
          qr_q  <= qr_d;
          cnt_q <= cnt_q + CNT_W'(1);
          // Last step lands directly in the result registers to avoid an extra cycle.
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            quot_q  <= qr_d;
            rem_q   <= pr_d[WIDTH-1:0];
            done_q  <= 1'b1;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
